// File: rtl/mic_mem_bridge_pkg.sv
// Shared RV32I microcontroller definitions: access codes, local-memory tag,
// funct3 load/store size codes and the external bridge state encoding.
package mic_mem_bridge_pkg;

    localparam logic [1:0] ACCESS_READ  = 2'd0;
    localparam logic [1:0] ACCESS_WRITE = 2'd1;
    localparam logic [1:0] ACCESS_CODE  = 2'd2;

    localparam logic [3:0] UC_TADDR = 4'h1;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/mic_lane_fmt.sv
// Byte-lane formatting: store data replication/strobes and load shift/extend.
// Purely combinational.
module mic_lane_fmt
    import mic_mem_bridge_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  ctrl_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        wdata_o = wdata_i;
        wstrb_o = 4'b1111;
        case (ctrl_i[1:0])
            2'd0: begin
                wdata_o = {4{wdata_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            2'd1: begin
                wdata_o = {2{wdata_i[15:0]}};
                wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Move the addressed byte/half down to bit 0 before extending.
    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        rdata_o = shifted;
        case (ctrl_i)
            FUNCT3_LB:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            FUNCT3_LBU: rdata_o = {24'h0, shifted[7:0]};
            FUNCT3_LH:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            FUNCT3_LHU: rdata_o = {16'h0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mic_mem_bridge.sv
// External memory bridge: stalls the CPU while it runs one valid/ready/ack
// transaction downstream, with a timeout so a dead slave cannot hang the core.
module mic_mem_bridge
    import mic_mem_bridge_pkg::*;
#(
    parameter logic [3:0]  LOCAL_TADDR = UC_TADDR,
    parameter int          TO_BITS     = 8,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] w_mic_addr,
    input  logic [31:0] w_mic_wdata,
    input  logic        w_mic_mmuwe,
    input  logic [2:0]  w_mic_ctrl,
    input  logic [1:0]  w_mic_req,
    output logic        w_stall,
    output logic [31:0] w_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        r_err
);

    bridge_state_t state_q, state_d;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic [2:0]    ctrl_q;
    logic          we_q, err_q;
    logic [3:0]    wstrb_q;
    logic [TO_BITS-1:0] cnt_q;

    logic        new_req, to_hit, ld_rd, set_err, accept;
    logic [1:0]  fmt_addr_lo;
    logic [2:0]  fmt_ctrl;
    logic [31:0] fmt_wdata, fmt_rdata;
    logic [3:0]  fmt_wstrb;

    assign new_req = ((w_mic_req == ACCESS_READ) && (w_mic_addr[31:28] != LOCAL_TADDR))
                   || w_mic_mmuwe;
    assign accept  = (state_q == IDLE) && new_req;
    assign to_hit  = &cnt_q;

    // One formatter serves both directions: live CPU fields while idle (store
    // capture), registered fields once a transaction is in flight (load return).
    assign fmt_addr_lo = (state_q == IDLE) ? w_mic_addr[1:0] : addr_q[1:0];
    assign fmt_ctrl    = (state_q == IDLE) ? w_mic_ctrl      : ctrl_q;

    mic_lane_fmt u_fmt (
        .addr_lo_i (fmt_addr_lo),
        .ctrl_i    (fmt_ctrl),
        .wdata_i   (w_mic_wdata),
        .rdata_i   (m_rdata),
        .wdata_o   (fmt_wdata),
        .wstrb_o   (fmt_wstrb),
        .rdata_o   (fmt_rdata)
    );

    always_comb begin
        state_d = state_q;
        m_valid = 1'b0;
        ld_rd   = 1'b0;
        set_err = 1'b0;
        case (state_q)
            IDLE: if (new_req) state_d = REQ;
            REQ: begin
                if (to_hit) begin
                    state_d = DONE;
                    set_err = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    if (m_ready && m_ack) begin
                        state_d = DONE;
                        ld_rd   = !we_q;
                    end else if (m_ready) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (to_hit) begin
                    state_d = DONE;
                    set_err = 1'b1;
                end else if (m_ack) begin
                    state_d = DONE;
                    ld_rd   = !we_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign w_stall = RST_X && (accept || (state_q == REQ) || (state_q == WAIT));

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ctrl_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= w_mic_addr;
                ctrl_q  <= w_mic_ctrl;
                we_q    <= w_mic_mmuwe;
                wdata_q <= fmt_wdata;
                wstrb_q <= w_mic_mmuwe ? fmt_wstrb : 4'b0000;
                cnt_q   <= '0;
            end else if ((state_q == REQ) || (state_q == WAIT)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (ld_rd) rdata_q <= fmt_rdata;
            if (set_err) begin
                rdata_q <= ERR_DATA;
                err_q   <= 1'b1;
            end
        end
    end

    assign w_data  = rdata_q;
    assign r_err   = err_q;
    assign m_we    = we_q;
    assign m_addr  = {addr_q[31:2], 2'b00};
    assign m_wdata = wdata_q;
    assign m_wstrb = wstrb_q;

endmodule

// File: tb/tb_mic_mem_bridge.sv
// Scoreboard bench for mic_mem_bridge: byte-addressed reference memory model,
// randomized slave timing, monitor compares handshakes and CPU-side completions.
module tb_mic_mem_bridge;
    import mic_mem_bridge_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic [31:0] w_mic_addr, w_mic_wdata;
    logic        w_mic_mmuwe;
    logic [2:0]  w_mic_ctrl;
    logic [1:0]  w_mic_req;
    logic        w_stall, m_valid, m_ready, m_we, m_ack, r_err;
    logic [31:0] w_data, m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    always #5 CLK = ~CLK;

    mic_mem_bridge dut (
        .CLK(CLK), .RST_X(RST_X),
        .w_mic_addr(w_mic_addr), .w_mic_wdata(w_mic_wdata), .w_mic_mmuwe(w_mic_mmuwe),
        .w_mic_ctrl(w_mic_ctrl), .w_mic_req(w_mic_req),
        .w_stall(w_stall), .w_data(w_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ack(m_ack), .m_rdata(m_rdata),
        .r_err(r_err)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        int          stalls;   // -1: not checked
        logic [31:0] data;
        logic        err;
    } done_t;

    localparam logic [2:0] LD_F3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    localparam logic [2:0] ST_F3 [3] = '{3'b000, 3'b001, 3'b010};

    req_t  exp_req_q[$];
    done_t exp_done_q[$];
    int    checks = 0;
    int    passes = 0;

    logic [31:0] sl_mem [16];
    logic [7:0]  mdl_b [64];
    logic [31:0] mdl_wdata;
    logic        mdl_err;
    int          sl_rdly = 0, sl_adly = 0;
    bit          sl_hold = 0, sl_spur = 0, sl_late = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        sl_mem[a[5:2]] = w;
        for (int i = 0; i < 4; i++) mdl_b[{a[5:2], 2'b00} + i] = w[8*i +: 8];
    endtask

    function automatic req_t mdl_store(input logic [31:0] a, input logic [31:0] wd,
                                       input logic [2:0] ctrl);
        req_t r;
        int   i;
        i = int'(a[5:0]);
        r.we   = 1'b1;
        r.addr = {a[31:2], 2'b00};
        case (ctrl[1:0])
            2'd0: begin
                r.wdata = {4{wd[7:0]}};
                r.wstrb = 4'(1 << a[1:0]);
                mdl_b[i] = wd[7:0];
            end
            2'd1: begin
                r.wdata = {2{wd[15:0]}};
                r.wstrb = 4'(3 << a[1:0]);
                mdl_b[i] = wd[7:0];
                mdl_b[i+1] = wd[15:8];
            end
            default: begin
                r.wdata = wd;
                r.wstrb = 4'hF;
                for (int k = 0; k < 4; k++) mdl_b[i+k] = wd[8*k +: 8];
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] ctrl);
        int      i;
        byte     sb;
        shortint sh;
        i = int'(a[5:0]);
        case (ctrl)
            3'b000: begin sb = byte'(mdl_b[i]); return int'(sb); end
            3'b100: return {24'h0, mdl_b[i]};
            3'b001: begin sh = shortint'({mdl_b[i+1], mdl_b[i]}); return int'(sh); end
            3'b101: return {16'h0, mdl_b[i+1], mdl_b[i]};
            default: return {mdl_b[i+3], mdl_b[i+2], mdl_b[i+1], mdl_b[i]};
        endcase
    endfunction

    // Downstream slave: ready after sl_rdly cycles of valid, ack sl_adly cycles later.
    initial begin : slave
        int rwait, acnt;
        bit busy;
        logic [31:0] rd;
        rwait = 0; acnt = 0; busy = 0; rd = '0;
        m_ready = 1'b0; m_ack = 1'b0; m_rdata = '0;
        forever begin
            @(posedge CLK); #2;
            m_ready = 1'b0; m_ack = 1'b0; m_rdata = $urandom;
            if (!RST_X) begin
                rwait = 0; busy = 0;
            end else if (busy) begin
                if (acnt == 0) begin m_ack = 1'b1; m_rdata = rd; busy = 0; end
                else acnt--;
            end else if (sl_late) begin
                m_ack = 1'b1; sl_late = 0;
            end else if (m_valid && !sl_hold) begin
                if (rwait < sl_rdly) begin
                    rwait++;
                    if (sl_spur) m_ack = 1'b1;
                end else begin
                    m_ready = 1'b1; rwait = 0;
                    if (m_we)
                        for (int b = 0; b < 4; b++)
                            if (m_wstrb[b]) sl_mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
                    rd = sl_mem[m_addr[5:2]];
                    if (sl_adly == 0) begin m_ack = 1'b1; m_rdata = rd; end
                    else begin busy = 1; acnt = sl_adly - 1; end
                end
            end
        end
    end

    initial begin : monitor
        int scnt;
        req_t e;
        done_t d;
        scnt = 0;
        forever begin
            @(negedge CLK);
            if (!RST_X) begin
                scnt = 0;
            end else begin
                if (m_valid && m_ready) begin
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        $display("FAIL handshake: unexpected request at addr %h at %0t", m_addr, $time);
                    end else begin
                        e = exp_req_q.pop_front();
                        chk("m_we", 32'(m_we), 32'(e.we));
                        chk("m_addr", m_addr, e.addr);
                        chk("m_wstrb", 32'(m_wstrb), 32'(e.wstrb));
                        if (e.we) chk("m_wdata", m_wdata, e.wdata);
                    end
                end
                if (w_stall) begin
                    scnt++;
                end else if (scnt > 0) begin
                    if (exp_done_q.size() == 0) begin
                        checks++;
                        $display("FAIL completion: unexpected stall release at %0t", $time);
                    end else begin
                        d = exp_done_q.pop_front();
                        if (d.stalls >= 0) chk("stall_cycles", scnt, d.stalls);
                        chk("w_data", w_data, d.data);
                        chk("r_err", 32'(r_err), 32'(d.err));
                    end
                    scnt = 0;
                end
            end
        end
    end

    task automatic access(input logic [1:0] req, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] ctrl,
                          input int rdly, input int adly);
        bit    nw;
        req_t  r;
        done_t d;
        int    n;
        @(posedge CLK); #1;
        sl_rdly = rdly; sl_adly = adly;
        w_mic_req = req; w_mic_mmuwe = wr; w_mic_addr = addr;
        w_mic_wdata = wd; w_mic_ctrl = ctrl;
        nw = wr || (req == ACCESS_READ && addr[31:28] != UC_TADDR);
        if (nw) begin
            if (wr) begin
                r = mdl_store(addr, wd, ctrl);
            end else begin
                r = '{we: 1'b0, addr: {addr[31:2], 2'b00}, wdata: 32'h0, wstrb: 4'h0};
                mdl_wdata = mdl_load(addr, ctrl);
            end
            if (sl_hold) begin
                mdl_wdata = 32'hDEADBEEF;
                mdl_err = 1'b1;
            end else begin
                exp_req_q.push_back(r);
            end
            d.stalls = sl_hold ? -1 : 2 + rdly + adly;
            d.data = mdl_wdata;
            d.err = mdl_err;
            exp_done_q.push_back(d);
            @(negedge CLK);
            chk("stall_same_cycle", 32'(w_stall), 32'd1);
            for (n = 0; n < 600; n++) begin
                @(negedge CLK);
                if (!w_stall) break;
            end
            if (n == 600) begin
                checks++;
                $display("FAIL completion_bound: stall never released for addr %h", addr);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                @(negedge CLK);
                chk("ignored_stall", 32'(w_stall), 32'd0);
                chk("ignored_valid", 32'(m_valid), 32'd0);
            end
        end
        @(posedge CLK); #1;
        w_mic_req = 2'd3; w_mic_mmuwe = 1'b0;
    endtask

    initial begin : main
        req_t r;
        logic [31:0] a;
        logic [3:0]  hi;
        logic [2:0]  f3;
        int kind, rd, ad;

        w_mic_addr = 32'h3000_0000; w_mic_wdata = '0; w_mic_mmuwe = 1'b0;
        w_mic_ctrl = 3'b010; w_mic_req = ACCESS_READ;
        for (int i = 0; i < 16; i++) preload(32'(i * 4), $urandom);
        mdl_wdata = '0; mdl_err = 1'b0;

        // A request is presented during reset: stall must stay low.
        #12;
        chk("rst_stall", 32'(w_stall), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_r_err", 32'(r_err), 32'd0);
        w_mic_req = 2'd3;
        @(posedge CLK); #3 RST_X = 1'b1;

        access(ACCESS_WRITE, 1, 32'h2000_0004, 32'h1234_5678, FUNCT3_SW, 0, 0);
        access(ACCESS_WRITE, 1, 32'h2000_0003, 32'h0000_00A5, FUNCT3_SB, 0, 0);
        preload(32'h3000_0000, 32'h0080_FF11);
        access(ACCESS_READ, 0, 32'h3000_0002, 32'h0, FUNCT3_LBU, 0, 0);
        access(ACCESS_READ, 0, 32'h3000_0002, 32'h0, FUNCT3_LB, 1, 2);
        access(ACCESS_READ, 0, 32'h3000_0002, 32'h0, FUNCT3_LH, 0, 1);
        access(ACCESS_READ, 0, 32'h3000_0000, 32'h0, FUNCT3_LH, 2, 0);
        access(ACCESS_READ, 0, 32'h3000_0000, 32'h0, FUNCT3_LHU, 0, 0);
        access(ACCESS_READ, 0, 32'h1000_0010, 32'h0, FUNCT3_LW, 0, 0);
        access(ACCESS_CODE, 0, 32'h2000_0000, 32'h0, FUNCT3_LW, 0, 0);
        sl_spur = 1;
        access(ACCESS_READ, 0, 32'h2000_0004, 32'h0, FUNCT3_LW, 3, 0);

        for (int k = 0; k < 120; k++) begin
            kind = $urandom_range(0, 9);
            hi = ($urandom_range(0, 1) != 0) ? 4'h2 : 4'h3;
            rd = $urandom_range(0, 3);
            ad = $urandom_range(0, 3);
            sl_spur = ($urandom_range(0, 1) != 0);
            a = {hi, 22'($urandom), 6'($urandom)};
            if (kind < 4) begin
                f3 = LD_F3[$urandom_range(0, 4)];
                a[5:0] = a[5:0] & ((f3[1:0] == 2'd0) ? 6'h3F : (f3[1:0] == 2'd1) ? 6'h3E : 6'h3C);
                access(ACCESS_READ, 0, a, $urandom, f3, rd, ad);
            end else if (kind < 8) begin
                f3 = ST_F3[$urandom_range(0, 2)];
                a[5:0] = a[5:0] & ((f3[1:0] == 2'd0) ? 6'h3F : (f3[1:0] == 2'd1) ? 6'h3E : 6'h3C);
                access(ACCESS_WRITE, 1, a, $urandom, f3, rd, ad);
            end else if (kind == 8) begin
                access(ACCESS_READ, 0, {UC_TADDR, a[27:0]}, $urandom, FUNCT3_LW, rd, ad);
            end else begin
                access(2'($urandom_range(2, 3)), 0, a, $urandom, FUNCT3_LW, rd, ad);
            end
        end
        sl_spur = 0;

        // Dead slave: abort, then a late ack in IDLE must be ignored.
        sl_hold = 1;
        access(ACCESS_READ, 0, 32'h2000_0008, 32'h0, FUNCT3_LW, 0, 0);
        sl_hold = 0;
        sl_late = 1;
        repeat (3) @(posedge CLK);
        access(ACCESS_WRITE, 1, 32'h2000_000C, 32'hCAFE_F00D, FUNCT3_SW, 0, 0);
        access(ACCESS_READ, 0, 32'h2000_000C, 32'h0, FUNCT3_LW, 1, 1);

        // Reset while the bridge waits for ack.
        @(posedge CLK); #1;
        sl_rdly = 0; sl_adly = 40;
        w_mic_req = ACCESS_READ; w_mic_mmuwe = 1'b0;
        w_mic_addr = 32'h2000_0010; w_mic_ctrl = FUNCT3_LW;
        r = '{we: 1'b0, addr: 32'h2000_0010, wdata: 32'h0, wstrb: 4'h0};
        exp_req_q.push_back(r);
        repeat (4) @(posedge CLK);
        #3 RST_X = 1'b0;
        #1;
        chk("midrst_valid", 32'(m_valid), 32'd0);
        chk("midrst_stall", 32'(w_stall), 32'd0);
        chk("midrst_w_data", w_data, 32'd0);
        chk("midrst_r_err", 32'(r_err), 32'd0);
        w_mic_req = 2'd3;
        mdl_wdata = '0; mdl_err = 1'b0;
        repeat (2) @(posedge CLK);
        #3 RST_X = 1'b1;
        access(ACCESS_READ, 0, 32'h3000_0014, 32'h0, FUNCT3_LW, 0, 0);
        access(ACCESS_WRITE, 1, 32'h2000_0016, 32'h0000_BEEF, FUNCT3_SH, 1, 0);

        repeat (3) @(posedge CLK);
        chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        chk("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
